if_fetch: RTL
=============

// Module: if_fetch
// PURPOSE
//  Instruction-fetch stage of the pipeline; feeds the IF/ID register. Holds the PC and a direct-mapped
//  instruction cache. Misses are filled through a word-wide request/done handshake with the memory
//  controller. Raises a stall request while a fill is pending and redirects the PC on taken jumps.
// PARAMETERS
//  ICACHE_ENTRIES  128  cache lines, one 32-bit word each; must be a power of 2
//  INDEX_BITS      7    log2(ICACHE_ENTRIES)
//  ADDR_WIDTH      17   significant address bits; tag = pc[ADDR_WIDTH-1:INDEX_BITS+2]
// PORTS
//  clk            in   1   clock
//  rst            in   1   synchronous reset, active-high
//  rdy            in   1   global ready; when low, all state is frozen
//  stall_ctrler0  in   1   stall_ctrler[0]; when high, hold the PC
//  jump_enable    in   1   taken branch/jump redirect
//  jump_target    in   32  redirect PC
//  mem_done       in   1   one-cycle pulse: mem_inst is valid for the word at mem_addr
//  mem_inst       in   32  fetched instruction word
//  mem_req        out  1   fill request; held high until the mem_done cycle
//  mem_addr       out  32  fill address, word aligned, stable while mem_req=1
//  if_pc          out  32  PC of the presented instruction; registered
//  if_inst        out  32  instruction on a hit, else 0 (bubble); combinational from cache
//  if_stall_req   out  1   high when the current PC misses or a fill is in flight
// BEHAVIOUR
//  - Reset: pc=0, all valid bits=0, state=IDLE, mem_req=0, mem_addr=0.
//    Outputs: if_inst=0, if_stall_req=1 (cold miss).
//    Reset mid-fill abandons the fill; a late mem_done after reset is ignored (state IDLE).
//  - rdy=0: no register or cache write; outputs reflect frozen state.
//  - hit = valid[idx] && tag[idx]==pc[ADDR_WIDTH-1:INDEX_BITS+2], with idx=pc[INDEX_BITS+1:2].
//  - FSM states: IDLE, MEM_WAIT, DISCARD.
//    IDLE
//      - hit: if_inst=data[idx], if_stall_req=0.
//      - PC update priority: jump_enable -> pc<=jump_target; else stall_ctrler0 -> hold;
//        else pc<=pc+4 (32-bit wrap).
//      - miss and no jump: next edge mem_req<=1, mem_addr<=pc, state<=MEM_WAIT.
//      - miss with jump: pc<=jump_target only; no request issued.
//    MEM_WAIT
//      - if_inst=0, if_stall_req=1; PC held unless jump.
//      - mem_done: write data/tag/valid at index of mem_addr, mem_req<=0, state<=IDLE.
//        The instruction is presented as a hit the next cycle.
//      - jump_enable without mem_done: pc<=jump_target, state<=DISCARD, mem_req stays high.
//      - jump_enable with mem_done: fill is written, pc<=jump_target, state<=IDLE.
//    DISCARD
//      - if_inst=0, if_stall_req=1.
//      - mem_done: still fill the cache (the word is valid for mem_addr), mem_req<=0, state<=IDLE.
//      - Further jumps only update pc.
//  - Latency: miss seen at cycle t -> mem_req high from t+1 -> mem_done at t+1+L
//    -> hit output at t+2+L.
//  - Sequential hits: one instruction per cycle, zero bubbles.
//  - Fill write and a hit read of the same index in the same cycle: the read returns the old contents
//    (write lands at the edge).
//  - A conflicting tag at the same index evicts the old line; no write-back (I-side is read-only).
//  - mem_addr[1:0] is always 0. jump_target is trusted aligned; bits [1:0] are forced to 0.
// TESTING
//  1) rst, then mem latency 3, word@0=0x00000013:
//     mem_req rises cycle 1, mem_addr=0, mem_done cycle 4;
//     cycle 5 if_pc=0, if_inst=0x13, if_stall_req=0.
//  2) Preload 0x0..0xC, run sequentially: if_pc 0,4,8,0xC on consecutive cycles, no stall_req,
//     no mem_req.
//  3) Miss at 0x10; jump_enable (target 0x100) in MEM_WAIT:
//     state DISCARD, mem_req held; on mem_done the line for 0x10 is valid;
//     next cycle a new request has mem_addr=0x100.
//  4) stall_ctrler0=1 for 3 cycles on a hit at 0x20: if_pc stays 0x20, if_inst stable;
//     the release cycle then advances to 0x24.
//  5) Fill 0x40, then fetch 0x240 (same index, INDEX_BITS=7): miss, fill, then 0x40 misses again.
//  6) rdy=0 for 4 cycles during MEM_WAIT with mem_done held low:
//     pc, state, mem_req unchanged; resumes identically when rdy=1.
//     Also assert rst mid-fill: mem_req=0 next cycle, pc=0.

Source files
------------

// File: rtl/if_fetch.sv
// Instruction-fetch stage: PC register and a direct-mapped, one-word-per-line
// instruction cache. Misses are filled via a req/done handshake with memory.
// A jump taken while a fill is outstanding moves the PC at once. The fill is
// still written into the cache when it returns.
module if_fetch #(
  parameter int ICACHE_ENTRIES = 128,
  parameter int INDEX_BITS     = 7,
  parameter int ADDR_WIDTH     = 17
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        stall_ctrler0,
  input  logic        jump_enable,
  input  logic [31:0] jump_target,
  input  logic        mem_done,
  input  logic [31:0] mem_inst,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        if_stall_req
);

  localparam int TAG_W = ADDR_WIDTH - INDEX_BITS - 2;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEM_WAIT = 2'd1,
    DISCARD  = 2'd2
  } state_t;

  state_t              state;
  state_t              state_next;
  logic [31:0]         pc;
  logic [31:0]         pc_next;
  logic                mem_req_next;
  logic [31:0]         mem_addr_next;
  logic                fill_en;

  // Cache storage: valid bits are control and get reset; tag/data never need it
  logic [ICACHE_ENTRIES-1:0] valid;
  logic [TAG_W-1:0]          tag_mem  [ICACHE_ENTRIES];
  logic [31:0]               data_mem [ICACHE_ENTRIES];

  logic [INDEX_BITS-1:0] rd_idx;
  logic [TAG_W-1:0]      rd_tag;
  logic [INDEX_BITS-1:0] wr_idx;
  logic [TAG_W-1:0]      wr_tag;
  logic                  hit;
  logic                  present;
  logic [31:0]           jump_pc;

  // Lookup address comes from the PC, fill address from the outstanding request
  assign rd_idx  = pc[INDEX_BITS+1:2];
  assign rd_tag  = pc[ADDR_WIDTH-1:INDEX_BITS+2];
  assign wr_idx  = mem_addr[INDEX_BITS+1:2];
  assign wr_tag  = mem_addr[ADDR_WIDTH-1:INDEX_BITS+2];
  assign jump_pc = jump_target & ~32'd3;

  // Hit detection and presented instruction; a bubble whenever not a clean IDLE hit
  always_comb begin
    hit          = valid[rd_idx] && (tag_mem[rd_idx] == rd_tag);
    present      = (state == IDLE) && hit;
    if_inst      = present ? data_mem[rd_idx] : 32'd0;
    if_stall_req = !present;
  end

  assign if_pc = pc;

  // Next-state, PC and fill-request logic
  always_comb begin
    state_next    = state;
    pc_next       = pc;
    mem_req_next  = mem_req;
    mem_addr_next = mem_addr;
    fill_en       = 1'b0;
    case (state)
      IDLE: begin
        if (jump_enable) begin
          // A miss under a jump is simply abandoned: the new PC gets looked up next
          pc_next = jump_pc;
        end else if (!hit) begin
          mem_req_next  = 1'b1;
          mem_addr_next = pc & ~32'd3;
          state_next    = MEM_WAIT;
        end else if (!stall_ctrler0) begin
          pc_next = pc + 32'd4;
        end
      end
      MEM_WAIT: begin
        if (mem_done) begin
          fill_en      = 1'b1;
          mem_req_next = 1'b0;
          state_next   = IDLE;
        end else if (jump_enable) begin
          // Keep the request alive so the memory handshake completes cleanly
          state_next = DISCARD;
        end
        if (jump_enable) begin
          pc_next = jump_pc;
        end
      end
      DISCARD: begin
        // The returning word is still correct for mem_addr, so keep it
        if (mem_done) begin
          fill_en      = 1'b1;
          mem_req_next = 1'b0;
          state_next   = IDLE;
        end
        if (jump_enable) begin
          pc_next = jump_pc;
        end
      end
      default: begin
        state_next   = IDLE;
        mem_req_next = 1'b0;
      end
    endcase
  end

  // Control registers: reset wins, rdy low freezes everything
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      pc       <= 32'd0;
      mem_req  <= 1'b0;
      mem_addr <= 32'd0;
    end else if (rdy) begin
      state    <= state_next;
      pc       <= pc_next;
      mem_req  <= mem_req_next;
      mem_addr <= mem_addr_next;
    end
  end

  // Valid bits: cleared by reset, set by a completed fill
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= '0;
    end else if (rdy && fill_en) begin
      valid[wr_idx] <= 1'b1;
    end
  end

  // Tag/data write on fill; a same-cycle read still sees the old line
  always_ff @(posedge clk) begin
    if (!rst && rdy && fill_en) begin
      tag_mem[wr_idx]  <= wr_tag;
      data_mem[wr_idx] <= mem_inst;
    end
  end

endmodule
